// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux; drives sel and flags settled output.
// Latency: grant one edge after request, valid SETTLE_CYCLES edges after grant.
// Backpressure: none; requesters hold req until done, owner is forced off after MAX_HOLD valid cycles.
module mux4_rr_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 16,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_t;

    localparam bit HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam bit HAS_TIMEOUT = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(HAS_SETTLE ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HAS_TIMEOUT ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       sel_q;
    logic [3:0]       gnt_q;
    logic             valid_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       pick_d;
    logic [1:0]       cand;
    logic             owner_req;

    // sel_q is the owner index whenever a grant is outstanding.
    assign owner_req = req[sel_q];

    // Scan from the pointer upward (mod 4); the closest set bit wins.
    always_comb begin
        pick_d = ptr_q;
        cand   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                pick_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q <= 4'b0001 << pick_d;
                        sel_q <= pick_d;
                        if (HAS_SETTLE) begin
                            state_q <= SETTLE;
                            cnt_q   <= SETTLE_INIT;
                        end else begin
                            state_q <= GRANT;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'd0;
                        ptr_q   <= sel_q + 2'd1;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= GRANT;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                GRANT: begin
                    if (!owner_req || (HAS_TIMEOUT && cnt_q == HOLD_LAST)) begin
                        state_q   <= IDLE;
                        gnt_q     <= 4'd0;
                        valid_q   <= 1'b0;
                        ptr_q     <= sel_q + 2'd1;
                        cnt_q     <= '0;
                        timeout_q <= owner_req;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'd0;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter with default parameters (SETTLE_CYCLES=2, MAX_HOLD=16).
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       timeout;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[15];
    logic [3:0] oh;
    logic [1:0] o2;

    always #5 clk = ~clk;

    mux4_rr_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .timeout (timeout)
    );

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                                input logic v, input logic t);
        vec_t x;
        x.req     = r;
        x.gnt     = g;
        x.sel     = s;
        x.valid   = v;
        x.timeout = t;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of req, then compare the outputs produced by that edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        req = v.req;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".gnt"},     8'(gnt),     8'(e.gnt));
        chk({tag, ".sel"},     8'(sel),     8'(e.sel));
        chk({tag, ".valid"},   8'(valid),   8'(e.valid));
        chk({tag, ".timeout"}, 8'(timeout), 8'(e.timeout));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"},     8'(gnt),     8'h0);
        chk({tag, ".sel"},     8'(sel),     8'h0);
        chk({tag, ".valid"},   8'(valid),   8'h0);
        chk({tag, ".timeout"}, 8'(timeout), 8'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (!$onehot0(gnt) || (valid && (gnt != (4'b0001 << sel)))) begin
                errors++;
                $display("FAIL invariant gnt=%b sel=%0d valid=%b", gnt, sel, valid);
            end
        end
    end

    initial begin
        // Starts with pointer=1 and sel=00 (previous owner was 0).
        tbl[0]  = mk(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
        tbl[1]  = mk(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
        tbl[2]  = mk(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        tbl[3]  = mk(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        tbl[4]  = mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[5]  = mk(4'b1001, 4'b1000, 2'd3, 1'b0, 1'b0);
        tbl[6]  = mk(4'b1001, 4'b1000, 2'd3, 1'b0, 1'b0);
        tbl[7]  = mk(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
        tbl[8]  = mk(4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0);
        tbl[9]  = mk(4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0);
        tbl[10] = mk(4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0);
        tbl[11] = mk(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
        tbl[12] = mk(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[13] = mk(4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        tbl[14] = mk(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

        rst_n = 1'b0;
        req   = 4'b0000;
        #12;
        chk_zero("reset_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("reset_idle");

        // Fairness: all four requesting, order 0,1,2,3,0 with one idle cycle between.
        for (int n = 0; n < 5; n++) begin
            o2 = 2'(n);
            oh = 4'b0001 << o2;
            step(mk(4'hF, oh, o2, 1'b0, 1'b0), "rr_grant");
            step(mk(4'hF, oh, o2, 1'b0, 1'b0), "rr_settle");
            repeat (3) step(mk(4'hF, oh, o2, 1'b1, 1'b0), "rr_valid");
            step(mk(4'hF & ~oh, 4'b0000, o2, 1'b0, 1'b0), "rr_release");
        end

        for (int i = 0; i < 15; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Pointer should now be 2 after the settle abort: 0110 picks 2, not 1.
        step(mk(4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0), "rst_grant");
        step(mk(4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0), "rst_settle");
        step(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0), "rst_valid");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        #1;
        rst_n = 1'b1;
        // A stale pointer of 2 would pick 3 here; a restarted pointer picks 0.
        step(mk(4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0), "rst_ptr0");
        step(mk(4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0), "rst_ptr0_settle");
        step(mk(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0), "rst_ptr0_valid");
        step(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0), "rst_ptr0_release");

        // Hold timeout: valid for exactly 16 cycles, then forced release with a timeout pulse.
        step(mk(4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0), "to_grant");
        step(mk(4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0), "to_settle");
        for (int c = 0; c < 16; c++) begin
            step(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0), $sformatf("to_hold%0d", c));
        end
        step(mk(4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1), "to_force");
        step(mk(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0), "to_next");
        step(mk(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0), "to_next_settle");
        step(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0), "to_next_valid");
        step(mk(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0), "to_next_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
